// File: rtl/harb_cmd_pkg.sv
// Shared definitions for the voice command sequencer.
//   - OPC_W: width of the opcode field at the top of every command word.
//   - opcode_e: NOP / LOAD_ALL / GATE / LOAD_ONE.
//   - state_e: sequencer FSM states.
//   - op_msb / mask_msb: MSB positions of the opcode and voice-mask fields
//     for a given command word width.
package harb_cmd_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP      = 4'd0,
        OP_LOAD_ALL = 4'd1,
        OP_GATE     = 4'd2,
        OP_LOAD_ONE = 4'd3
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD_ALL = 2'd1,
        ST_LOAD_ONE = 2'd2
    } state_e;

    function automatic int op_msb(input int data_w);
        return data_w - 1;
    endfunction

    function automatic int mask_msb(input int data_w);
        return data_w - 1 - OPC_W;
    endfunction

endpackage

// File: rtl/cmd_idle_timer.sv
// Idle-cycle timer for an in-progress parameter load.
//   clk    : clock
//   rst    : asynchronous active-high reset
//   en     : a load is in progress (timer runs only while high)
//   clr    : a word was accepted this cycle (restarts the count)
//   expire : high in the TIMEOUT_CYC-th consecutive enabled cycle without clr
// Used by voice_cmd_sequencer only when CMD_TIMEOUT_EN is defined.
module cmd_idle_timer #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    // The cycle holding LAST is itself the TIMEOUT_CYC-th idle cycle.
    assign expire = en && !clr && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!en || clr || expire) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/voice_cmd_sequencer.sv
// Command decoder between the host command FIFO and the voice parameter store.
// Decodes a valid/ready command stream, bulk- or single-loads voice parameters
// through a registered write port with back-pressure, and drives per-voice
// gate/trigger and commit strobes.
//
// Ports:
//   clk147, rst            clock, asynchronous active-high reset
//   cmd_data/valid/ready   command stream; a word moves when valid && ready
//   wr_en/addr/data/mask   parameter write; the store takes it when wr_en && wr_ready
//   wr_ready               store back-pressure
//   commit                 1-cycle pulse: masked voices latch shadow params
//   gate, trig             gate level per voice, trig pulse on 0->1 gate edges
//   busy                   FSM is inside a load
//   err_op                 sticky illegal opcode / index flag
//   abort                  1-cycle pulse when a load times out
//
// Optional feature: define CMD_TIMEOUT_EN to abort loads that stall for
// TIMEOUT_CYC cycles without an accepted word. Without it loads wait forever
// and abort is tied low.
module voice_cmd_sequencer
    import harb_cmd_pkg::*;
#(
    parameter int NUM_VOICES  = 8,
    parameter int NUM_PARAMS  = 56,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 4096,
    localparam int PIDX_W     = $clog2(NUM_PARAMS)
) (
    input  logic                  clk147,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     cmd_data,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic                  wr_en,
    output logic [PIDX_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic [NUM_VOICES-1:0] wr_mask,
    input  logic                  wr_ready,
    output logic [NUM_VOICES-1:0] commit,
    output logic [NUM_VOICES-1:0] gate,
    output logic [NUM_VOICES-1:0] trig,
    output logic                  busy,
    output logic                  err_op,
    output logic                  abort
);

    localparam int OP_MSB   = op_msb(DATA_W);
    localparam int MASK_MSB = mask_msb(DATA_W);
    localparam logic [PIDX_W-1:0] LAST_IDX  = PIDX_W'(NUM_PARAMS - 1);
    localparam logic [PIDX_W:0]   IDX_LIMIT = (PIDX_W + 1)'(NUM_PARAMS);

    state_e state_q, state_d;

    logic [PIDX_W-1:0]     cnt_q;
    logic [PIDX_W-1:0]     idx_q;
    logic [NUM_VOICES-1:0] mask_q;
    logic                  last_q;   // pending write is the final one of its load

    logic [OPC_W-1:0]      f_op;
    logic [NUM_VOICES-1:0] f_mask;
    logic [PIDX_W-1:0]     f_idx;
    logic                  idx_ok;

    logic accept, wr_done, expire;
    logic load_all_start, load_one_start, gate_set, err_set;
    logic data_take, data_last;
    logic [PIDX_W-1:0] data_addr;

    // Handshakes: a command word moves on cmd_valid && cmd_ready; a parameter
    // write moves on wr_en && wr_ready. cmd_ready only requires that the write
    // register is free or being emptied this cycle, so it is the same in every
    // state and each accepted load word always has a slot to land in.
    assign cmd_ready = !rst && (!wr_en || wr_ready);
    assign accept    = cmd_valid && cmd_ready;
    assign wr_done   = wr_en && wr_ready;

    assign f_op   = cmd_data[OP_MSB -: OPC_W];
    assign f_mask = cmd_data[MASK_MSB -: NUM_VOICES];
    assign f_idx  = cmd_data[PIDX_W-1:0];
    assign idx_ok = ({1'b0, f_idx} < IDX_LIMIT);

    assign busy   = (state_q != ST_IDLE);
    assign commit = (wr_done && last_q) ? wr_mask : '0;

`ifdef CMD_TIMEOUT_EN
    cmd_idle_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_idle_timer (
        .clk   (clk147),
        .rst   (rst),
        .en    (busy),
        .clr   (accept),
        .expire(expire)
    );

    always_ff @(posedge clk147 or posedge rst) begin
        if (rst) begin
            abort <= 1'b0;
        end else begin
            abort <= expire;
        end
    end
`else
    assign expire = 1'b0;
    assign abort  = 1'b0;
`endif

    always_ff @(posedge clk147 or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Words accepted inside a load are data only; opcodes are decoded in IDLE.
    always_comb begin
        state_d        = state_q;
        load_all_start = 1'b0;
        load_one_start = 1'b0;
        gate_set       = 1'b0;
        err_set        = 1'b0;
        data_take      = 1'b0;
        data_last      = 1'b0;
        data_addr      = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (f_op)
                        OP_NOP: ;
                        OP_LOAD_ALL: begin
                            state_d        = ST_LOAD_ALL;
                            load_all_start = 1'b1;
                        end
                        OP_GATE: gate_set = 1'b1;
                        OP_LOAD_ONE: begin
                            if (idx_ok) begin
                                state_d        = ST_LOAD_ONE;
                                load_one_start = 1'b1;
                            end else begin
                                err_set = 1'b1;
                            end
                        end
                        default: err_set = 1'b1;
                    endcase
                end
            end
            ST_LOAD_ALL: begin
                if (accept) begin
                    data_take = 1'b1;
                    data_addr = cnt_q;
                    if (cnt_q == LAST_IDX) begin
                        data_last = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end else if (expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD_ONE: begin
                if (accept) begin
                    data_take = 1'b1;
                    data_addr = idx_q;
                    data_last = 1'b1;
                    state_d   = ST_IDLE;
                end else if (expire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk147 or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_mask <= '0;
            gate    <= '0;
            trig    <= '0;
            err_op  <= 1'b0;
        end else begin
            if (load_all_start) begin
                mask_q <= f_mask;
                cnt_q  <= '0;
            end else if (load_one_start) begin
                mask_q <= f_mask;
                idx_q  <= f_idx;
            end else if (data_take && state_q == ST_LOAD_ALL) begin
                cnt_q <= data_last ? '0 : cnt_q + PIDX_W'(1);
            end else if (expire) begin
                cnt_q <= '0;
            end

            // A new word can only be taken when the old write is leaving,
            // so loading here never overwrites an unaccepted write.
            if (data_take) begin
                wr_en   <= 1'b1;
                wr_addr <= data_addr;
                wr_data <= cmd_data;
                wr_mask <= mask_q;
                last_q  <= data_last;
            end else if (wr_done) begin
                wr_en  <= 1'b0;
                last_q <= 1'b0;
            end

            if (gate_set) begin
                gate <= f_mask;
            end
            trig <= gate_set ? (f_mask & ~gate) : '0;

            if (err_set) begin
                err_op <= 1'b1;
            end
        end
    end

endmodule
